// File: rtl/qam_cfg_sweeper.sv
// Steps a modulator through every mod/filter/baud/carrier combination, holding each
// accepted config for a programmable dwell time and pulsing done after the last one.
module qam_cfg_sweeper #(
  parameter logic [15:0] FREQ_MIN  = 16'd10000,
  parameter logic [15:0] FREQ_MAX  = 16'd60000,
  parameter logic [15:0] FREQ_STEP = 16'd1000,
  parameter int          DWELL_W   = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell_cycles,
  input  logic               cfg_ack,
  output logic               mod_type,
  output logic [1:0]         baud_rate,
  output logic               filter_enable,
  output logic               use_sqrt_rcos,
  output logic [15:0]        carrier_freq_set,
  output logic               cfg_valid,
  output logic               busy,
  output logic               done,
  output logic [11:0]        step_idx
);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_DWELL, S_ADVANCE} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_mod, w_mod_nxt;
  logic [1:0]         r_baud, w_baud_nxt;
  logic [1:0]         r_fmode, w_fmode_nxt;
  logic [15:0]        r_freq, w_freq_nxt;
  logic [11:0]        r_step, w_step_nxt;
  logic [DWELL_W-1:0] r_dwell, w_dwell_nxt;
  logic               w_done;
  logic [16:0]        w_sum;
  logic               w_wrap;
  logic               w_last;

  // 17-bit sum so a step past 16'hFFFF is seen as a wrap rather than aliasing low
  assign w_sum  = {1'b0, r_freq} + {1'b0, FREQ_STEP};
  assign w_wrap = w_sum[16] || (w_sum > {1'b0, FREQ_MAX});
  assign w_last = r_mod && (r_fmode == 2'd2) && (r_baud == 2'd3) && w_wrap;

  always_comb begin
    w_state_nxt = r_state;
    w_mod_nxt   = r_mod;
    w_baud_nxt  = r_baud;
    w_fmode_nxt = r_fmode;
    w_freq_nxt  = r_freq;
    w_step_nxt  = r_step;
    w_dwell_nxt = r_dwell;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          w_mod_nxt   = 1'b0;
          w_baud_nxt  = 2'd0;
          w_fmode_nxt = 2'd0;
          w_freq_nxt  = FREQ_MIN;
          w_step_nxt  = 12'd0;
          w_state_nxt = S_APPLY;
        end
      end
      S_APPLY: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else if (cfg_ack) begin
          w_dwell_nxt = (dwell_cycles == '0) ? DWELL_W'(1) : dwell_cycles;
          w_state_nxt = S_DWELL;
        end
      end
      S_DWELL: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else if (r_dwell <= DWELL_W'(1)) begin
          w_state_nxt = S_ADVANCE;
        end else begin
          w_dwell_nxt = r_dwell - DWELL_W'(1);
        end
      end
      S_ADVANCE: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else if (w_last) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_APPLY;
          if (r_step != 12'hFFF) w_step_nxt = r_step + 12'd1;
          // carry ripples carrier -> baud -> filter mode -> mod type
          if (!w_wrap) begin
            w_freq_nxt = w_sum[15:0];
          end else begin
            w_freq_nxt = FREQ_MIN;
            if (r_baud != 2'd3) begin
              w_baud_nxt = r_baud + 2'd1;
            end else begin
              w_baud_nxt = 2'd0;
              if (r_fmode != 2'd2) begin
                w_fmode_nxt = r_fmode + 2'd1;
              end else begin
                w_fmode_nxt = 2'd0;
                w_mod_nxt   = ~r_mod;
              end
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mod   <= 1'b0;
      r_baud  <= 2'd0;
      r_fmode <= 2'd0;
      r_freq  <= FREQ_MIN;
      r_step  <= 12'd0;
      r_dwell <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mod   <= w_mod_nxt;
      r_baud  <= w_baud_nxt;
      r_fmode <= w_fmode_nxt;
      r_freq  <= w_freq_nxt;
      r_step  <= w_step_nxt;
      r_dwell <= w_dwell_nxt;
    end
  end

  assign mod_type         = r_mod;
  assign baud_rate        = r_baud;
  assign filter_enable    = (r_fmode != 2'd0);
  assign use_sqrt_rcos    = (r_fmode == 2'd2);
  assign carrier_freq_set = r_freq;
  assign step_idx         = r_step;
  assign cfg_valid        = (r_state == S_APPLY);
  assign done             = w_done;
  assign busy             = (r_state != S_IDLE) && !w_done;

endmodule

// File: tb/tb_qam_cfg_sweeper.sv
// Scoreboard bench: stimulus queues expected configs/dwell gaps, negedge monitors check handshakes and done.
module tb_qam_cfg_sweeper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, cfg_ack = 1'b0;
  logic [23:0] dwell_cycles = 24'd0;
  logic        mod_type, filter_enable, use_sqrt_rcos, cfg_valid, busy, done;
  logic [1:0]  baud_rate;
  logic [15:0] carrier_freq_set;
  logic [11:0] step_idx;

  logic        start2 = 1'b0, stop2 = 1'b0;
  logic        mod2, fe2, sr2, cv2, busy2, done2;
  logic [1:0]  baud2;
  logic [15:0] freq2;
  logic [11:0] step2;

  always #5 clk = ~clk;

  qam_cfg_sweeper #(.FREQ_MIN(16'd100), .FREQ_MAX(16'd300), .FREQ_STEP(16'd100), .DWELL_W(24)) u_dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .dwell_cycles(dwell_cycles), .cfg_ack(cfg_ack),
    .mod_type(mod_type), .baud_rate(baud_rate), .filter_enable(filter_enable), .use_sqrt_rcos(use_sqrt_rcos),
    .carrier_freq_set(carrier_freq_set), .cfg_valid(cfg_valid), .busy(busy), .done(done), .step_idx(step_idx)
  );

  qam_cfg_sweeper #(.FREQ_MIN(16'd65000), .FREQ_MAX(16'd65535), .FREQ_STEP(16'd500), .DWELL_W(24)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .stop(stop2), .dwell_cycles(24'd0), .cfg_ack(1'b1),
    .mod_type(mod2), .baud_rate(baud2), .filter_enable(fe2), .use_sqrt_rcos(sr2),
    .carrier_freq_set(freq2), .cfg_valid(cv2), .busy(busy2), .done(done2), .step_idx(step2)
  );

  typedef struct {
    int step;
    int mode;
    int fq;
    int dw;
  } exp_t;

  exp_t exp_q[$];
  int   exp_done_q[$];
  int   fq2_q[$];
  int   bd2_q[$];
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // expected config k for FREQ 100/200/300: freq innermost, then baud, filter mode, mod type
  task automatic push_cfg(input int k, input int dw);
    exp_t e;
    int fm, bd, md;
    fm = (k / 12) % 3;
    bd = (k / 3) % 4;
    md = k / 36;
    e.step = k;
    e.fq   = 100 * ((k % 3) + 1);
    e.mode = md * 16 + bd * 4 + ((fm != 0) ? 2 : 0) + ((fm == 2) ? 1 : 0);
    e.dw   = dw;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_step(input int s, input bit in_dwell);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (step_idx == 12'(s) && busy && (in_dwell ? !cfg_valid : cfg_valid)) begin
        ok = 1'b1;
        break;
      end
    end
    chk($sformatf("wait_step%0d_reached", s), int'(ok), 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mode"}, int'({mod_type, baud_rate, filter_enable, use_sqrt_rcos}), 0);
    chk({tag, "_freq"}, int'(carrier_freq_set), 100);
    chk({tag, "_step"}, int'(step_idx), 0);
    chk({tag, "_ctl"}, int'({cfg_valid, busy, done}), 0);
  endtask

  // monitor for main instance: field checks on each accepted config, gap checks between events
  int   cyc_since = 0;
  bit   have_prev = 1'b0;
  int   prev_dw = 0;
  always @(negedge clk) begin
    exp_t e;
    int   d;
    if (rst) begin
      have_prev = 1'b0;
    end else begin
      cyc_since++;
      if (done) begin
        done_cnt++;
        if (exp_done_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          d = exp_done_q.pop_front();
          chk("done_step", int'(step_idx), d);
        end
        if (have_prev) chk("done_gap", cyc_since, prev_dw + 1);
        have_prev = 1'b0;
      end else if (cfg_valid && cfg_ack && !stop) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_handshake", int'(step_idx), -1);
        end else begin
          e = exp_q.pop_front();
          chk("hs_step", int'(step_idx), e.step);
          chk("hs_freq", int'(carrier_freq_set), e.fq);
          chk("hs_mode", int'({mod_type, baud_rate, filter_enable, use_sqrt_rcos}), e.mode);
          if (have_prev) chk("hs_gap", cyc_since, prev_dw + 2);
          have_prev = 1'b1;
          prev_dw   = e.dw;
        end
        cyc_since = 0;
      end else if (!busy) begin
        have_prev = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    int f, b;
    if (!rst && cv2 && !stop2 && fq2_q.size() > 0) begin
      f = fq2_q.pop_front();
      b = bd2_q.pop_front();
      chk("wide_freq", int'(freq2), f);
      chk("wide_baud", int'(baud2), b);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    cyc(3);
    chk_reset_vals("reset");
    rst = 1'b0;
    cyc(2);
    chk_reset_vals("idle");

    // full sweep, ack tied high, 3-cycle dwell
    cfg_ack = 1'b1;
    dwell_cycles = 24'd3;
    for (int k = 0; k < 72; k++) push_cfg(k, 3);
    exp_done_q.push_back(71);
    pulse_start();
    dn = 0;
    for (int i = 0; i < 1000 && done_cnt == 0; i++) cyc(1);
    chk("sweep_done_seen", done_cnt, 1);
    cyc(3);
    chk("sweep_done_single", done_cnt, 1);
    chk("sweep_end_mode", int'({mod_type, baud_rate, filter_enable, use_sqrt_rcos}), 16 + 12 + 3);
    chk("sweep_end_freq", int'(carrier_freq_set), 300);
    chk("sweep_end_step", int'(step_idx), 71);
    chk("sweep_end_busy", int'({busy, cfg_valid}), 0);
    chk("sweep_q_empty", exp_q.size(), 0);

    // ack withheld in APPLY, then zero dwell, stop at step 7
    cfg_ack = 1'b0;
    dwell_cycles = 24'd0;
    for (int k = 0; k < 7; k++) push_cfg(k, 1);
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", int'({cfg_valid, busy}), 3);
      chk("hold_cfg", int'({step_idx, carrier_freq_set}), 100);
      cyc(1);
    end
    cfg_ack = 1'b1;
    wait_step(7, 1'b0);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk("stop_ctl", int'({cfg_valid, busy, done}), 0);
    chk("stop_step", int'(step_idx), 7);
    chk("stop_freq", int'(carrier_freq_set), 200);
    cyc(3);
    chk("stop_step_held", int'(step_idx), 7);
    chk("stop_q_empty", exp_q.size(), 0);
    start = 1'b1;
    stop = 1'b1;
    cyc(1);
    start = 1'b0;
    stop = 1'b0;
    cyc(1);
    chk("start_stop_idle", int'({cfg_valid, busy}), 0);

    // 5-cycle dwell
    dwell_cycles = 24'd5;
    for (int k = 0; k < 3; k++) push_cfg(k, 5);
    pulse_start();
    wait_step(3, 1'b0);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk("dwell5_q_empty", exp_q.size(), 0);
    chk("dwell5_idle", int'(busy), 0);

    // reset in DWELL at step 20
    dwell_cycles = 24'd3;
    for (int k = 0; k < 21; k++) push_cfg(k, 3);
    pulse_start();
    wait_step(20, 1'b1);
    rst = 1'b1;
    #1;
    chk_reset_vals("arst");
    cyc(2);
    rst = 1'b0;
    cyc(5);
    chk("post_rst_idle", int'({cfg_valid, busy}), 0);
    chk("post_rst_no_done", done_cnt, 1);
    chk("rst_q_empty", exp_q.size(), 0);

    // wide-range instance: 17-bit carry into baud
    fq2_q.push_back(65000); bd2_q.push_back(0);
    fq2_q.push_back(65500); bd2_q.push_back(0);
    fq2_q.push_back(65000); bd2_q.push_back(1);
    start2 = 1'b1;
    cyc(1);
    start2 = 1'b0;
    cyc(20);
    stop2 = 1'b1;
    cyc(1);
    stop2 = 1'b0;
    chk("wide_q_empty", fq2_q.size(), 0);
    chk("done_q_empty", exp_done_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
